diff_sat_accumulator: RTL and testbench

- Consumes the signed 16-bit difference stream and OvP/OvN overflow flags produced by the 16-bit subtractor stage in the 8-tap filter datapath.
- Replaces each overflowed difference with the saturated value, then accumulates TAPS consecutive samples.
- Emits one clamped 16-bit result per block over a valid/ready handshake.
- Sits between the subtractor and the filter output register.

---
 rtl/diff_sat_accumulator.sv | 87 ++++++++
 tb/tb_diff_sat_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/diff_sat_accumulator.sv
// diff_sat_accumulator: saturating block accumulator for the subtractor difference stream; DIFF_ACC_AVG_EN selects block-mean output instead of clamped sum
module diff_sat_accumulator #(
  parameter int TAPS  = 8,
  parameter int ACC_W = 16 + $clog2(TAPS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] sub_in,
  input  logic        ovp_in,
  input  logic        ovn_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] acc_out,
  output logic        sat_flag
);
  localparam int LG = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [LG-1:0] count;
  logic signed [ACC_W-1:0] acc, sum;
  logic [15:0] sample, res;
  logic accept, last, in_sat, clamp;
`ifdef DIFF_ACC_AVG_EN
  logic signed [ACC_W-1:0] rnd;
`else
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-15){1'b0}}, 15'h7FFF};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-15){1'b1}}, 15'h0000};
`endif
  // input correction, running sum and output transform of the sum after this accept
  always_comb begin
    accept = in_valid & in_ready;
    last = count == LG'(TAPS - 1);
    in_sat = ovp_in | ovn_in;
    sample = ovp_in ? 16'h7FFF : (ovn_in ? 16'h8000 : sub_in);
    sum = (state == ACC ? acc : '0) + {{(ACC_W-16){sample[15]}}, sample};
`ifdef DIFF_ACC_AVG_EN
    rnd = sum + ACC_W'(TAPS / 2);
    res = 16'(rnd >>> LG);
    clamp = 1'b0;
`else
    clamp = (sum > MAXV) || (sum < MINV);
    res = sum > MAXV ? 16'h7FFF : (sum < MINV ? 16'h8000 : sum[15:0]);
`endif
  end
  // block state machine with registered handshake outputs; clr behaves like reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      acc_out <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      acc_out <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      count <= count + 1'b1;
      sat_flag <= sat_flag | in_sat;
      state <= ACC;
      if (last) begin
        state <= DONE;
        in_ready <= 1'b0;
        out_valid <= 1'b1;
        acc_out <= res;
        sat_flag <= sat_flag | in_sat | clamp;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_diff_sat_accumulator.sv
// tb_diff_sat_accumulator: table vectors, corner sequences and random blocks against a behavioural model
module tb_diff_sat_accumulator;
  localparam int TAPS = 8;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, ovp_in = 0, ovn_in = 0, out_ready = 0;
  logic [15:0] sub_in = 0;
  logic in_ready, out_valid, sat_flag;
  logic [15:0] acc_out;
  int pass_cnt = 0, total = 0;
  logic [15:0] bd[TAPS];
  logic bp[TAPS], bn[TAPS];

  typedef struct {
    string nm;
    logic [15:0] first;
    logic fp, fn;
    logic [15:0] rest;
    int sum_o, sum_s, avg_o, avg_s;
  } vec_t;
  vec_t tbl[4];

  diff_sat_accumulator #(.TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .sub_in(sub_in), .ovp_in(ovp_in), .ovn_in(ovn_in), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fill(input logic [15:0] d);
    for (int i = 0; i < TAPS; i++) begin bd[i] = d; bp[i] = 0; bn[i] = 0; end
  endtask

  task automatic send(input logic [15:0] d, input logic p, input logic n, input int gap);
    int k = 0;
    repeat (gap) begin @(posedge clk); #1; end
    if (p && n) $display("note: illegal ovp_in&ovn_in driven");
    sub_in = d; ovp_in = p; ovn_in = n; in_valid = 1;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check("send timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; ovp_in = 0; ovn_in = 0;
  endtask

  task automatic do_block(input string nm, input int maxgap);
    for (int i = 0; i < TAPS; i++) begin
      if (i == TAPS - 1) check({nm, " no early out"}, out_valid, 0);
      send(bd[i], bp[i], bn[i], $urandom_range(maxgap, 0));
    end
    check({nm, " latency"}, out_valid, 1);
  endtask

  task automatic take(input string nm, input int eo, input int es, input int stall);
    repeat (stall) begin @(posedge clk); #1; end
    check({nm, " out_valid"}, out_valid, 1);
    check({nm, " acc_out"}, int'($signed(acc_out)), eo);
    check({nm, " sat"}, sat_flag, es);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({nm, " drop"}, out_valid, 0);
    check({nm, " ready back"}, in_ready, 1);
  endtask

  task automatic model(output int eo, output int es);
    int s = 0;
    es = 0;
    for (int i = 0; i < TAPS; i++) begin
      s += bp[i] ? 32767 : (bn[i] ? -32768 : int'($signed(bd[i])));
      es |= int'(bp[i] | bn[i]);
    end
`ifdef DIFF_ACC_AVG_EN
    eo = (s + TAPS / 2) >>> $clog2(TAPS);
`else
    eo = s;
    if (s > 32767) begin eo = 32767; es = 1; end
    if (s < -32768) begin eo = -32768; es = 1; end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int eo, es;
    tbl[0] = '{"basic", 16'd100, 0, 0, 16'd100, 800, 0, 100, 0};
    tbl[1] = '{"outclamp", 16'h7FFF, 0, 0, 16'h7FFF, 32767, 1, 32767, 0};
    tbl[2] = '{"ovp", 16'h8001, 1, 0, 16'h0000, 32767, 1, 4096, 1};
    tbl[3] = '{"ovn", 16'h7FFF, 0, 1, 16'hFFFF, -32768, 1, -4097, 1};
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst acc_out", acc_out, 0);
    check("rst sat", sat_flag, 0);
    rst_n = 1;
    for (int t = 0; t < 4; t++) begin
      fill(tbl[t].rest);
      bd[0] = tbl[t].first; bp[0] = tbl[t].fp; bn[0] = tbl[t].fn;
      do_block(tbl[t].nm, 0);
`ifdef DIFF_ACC_AVG_EN
      take(tbl[t].nm, tbl[t].avg_o, tbl[t].avg_s, 0);
`else
      take(tbl[t].nm, tbl[t].sum_o, tbl[t].sum_s, 0);
`endif
    end
    // backpressure: DONE must hold result and refuse samples
    fill(16'd9);
    model(eo, es);
    do_block("bp", 0);
    sub_in = 16'd7; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      check("bp stable valid", out_valid, 1);
      check("bp stable acc", int'($signed(acc_out)), eo);
      check("bp stable sat", sat_flag, es);
      check("bp in_ready low", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    check("bp drop", out_valid, 0);
    check("bp ready back", in_ready, 1);
    fill(16'd3);
    model(eo, es);
    do_block("bp next", 0);
    take("bp next", eo, es, 0);
    // gapped input
    fill(16'd5);
    model(eo, es);
    do_block("gap", 3);
    take("gap", eo, es, 0);
    // asynchronous reset mid-block
    fill(16'd1000);
    for (int i = 0; i < 3; i++) send(bd[i], 0, 0, 0);
    #3 rst_n = 0;
    #1;
    check("mid rst in_ready", in_ready, 1);
    check("mid rst out_valid", out_valid, 0);
    check("mid rst acc_out", acc_out, 0);
    @(posedge clk); #1;
    rst_n = 1;
    fill(16'd1);
    model(eo, es);
    do_block("after rst", 0);
    take("after rst", eo, es, 0);
    // clr in DONE beats a simultaneous handshake
    fill(16'd2);
    do_block("clr", 0);
    clr = 1; out_ready = 1;
    @(posedge clk); #1;
    clr = 0; out_ready = 0;
    check("clr out_valid", out_valid, 0);
    check("clr in_ready", in_ready, 1);
    check("clr acc_out", acc_out, 0);
    check("clr sat", sat_flag, 0);
    fill(16'd1);
    model(eo, es);
    do_block("after clr", 0);
    take("after clr", eo, es, 0);
    // random blocks against the model
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < TAPS; i++) begin
        int f = $urandom_range(7, 0);
        bd[i] = b[0] ? 16'($urandom_range(65535, 0)) : 16'($signed($urandom_range(400, 0)) - 200);
        bp[i] = f == 0;
        bn[i] = f == 1;
      end
      model(eo, es);
      do_block("rand", 2);
      take("rand", eo, es, $urandom_range(3, 0));
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
